mul_share_sched: RTL and testbench

// Shares one shift-add multiplier (4-iteration controller + datapath) between NREQ requesters.

---
 rtl/mul_share_sched_pkg.sv | 23 ++
 rtl/mul_share_sched_rr_arbiter.sv | 34 +++
 rtl/mul_share_sched.sv | 127 ++++++++++++
 tb/tb_mul_share_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_sched_pkg.sv
// Shared state encodings, default sizing and index helpers for the
// multiplier-sharing scheduler.
package mul_share_sched_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_W       = 4;
  localparam int DEF_TIMEOUT = 32;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  // (base + off) mod n, for base < n and off < n; valid for any n, not only powers of 2
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/mul_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting index at or
// after the pointer, wrapping at NREQ-1.
module rr_arbiter
  import mul_share_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [PW-1:0] cand;

  // Scan from the far end so the candidate closest to the pointer wins last.
  always_comb begin
    cand      = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'(wrap_add(int'(ptr), k, NREQ));
      if (req[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mul_share_sched.sv
// Time-shares one shift-add multiplier among NREQ requesters: round-robin
// accept, start/done sequencing, watchdog abort, one-hot response.
module mul_share_sched
  import mul_share_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*W-1:0]    rsp_product,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic              mul_done,
  input  logic [2*W-1:0]    mul_product
);

  // state        | meaning
  // ST_IDLE      | arbitrate; accept only while the multiplier reports idle
  // ST_START     | mul_start high for one cycle
  // ST_WAIT_BUSY | wait for mul_done to fall
  // ST_WAIT_DONE | wait for mul_done to rise, capture product
  // ST_RESP      | one-cycle response pulse to the owner

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [TW-1:0]   timer;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic            accept;
  logic            timeout_hit;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign accept      = (state == ST_IDLE) && grant_any && mul_done;
  assign req_ready   = accept ? grant : '0;
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign busy        = (state != ST_IDLE);
  assign mul_start   = (state == ST_START);

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESP) rsp_valid[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      timer       <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mul_a  <= req_a[int'(grant_idx)*W +: W];
            mul_b  <= req_b[int'(grant_idx)*W +: W];
            owner  <= grant_idx;
            rr_ptr <= PW'(wrap_add(int'(grant_idx), 1, NREQ));
            state  <= ST_START;
          end
        end
        ST_START: begin
          timer <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!mul_done) begin
            timer <= timer + TW'(1);
            state <= ST_WAIT_DONE;
          end else if (timeout_hit) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            state       <= ST_RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          // A completion on the final permitted cycle still counts as success.
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            state       <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            state       <= ST_RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_sched.sv
// Randomised scoreboard bench for mul_share_sched with a behavioural
// 4-iteration multiplier and a high-level round-robin reference model.
module tb_mul_share_sched;

  localparam int NREQ    = 4;
  localparam int W       = 4;
  localparam int TIMEOUT = 32;
  localparam int PWID    = 2 * W;
  localparam int LAT_NOM = W + 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [PWID-1:0]   rsp_product;
  logic              rsp_err, busy, mul_start;
  logic [W-1:0]      mul_a, mul_b;
  logic              mul_done;
  logic [PWID-1:0]   mul_product;

  always #5 clk = ~clk;

  mul_share_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  // Behavioural multiplier: done drops after start, rises W+2 cycles later with P.
  logic            m_done;
  logic [PWID-1:0] m_p;
  int              m_cnt;
  bit              dead = 0, hold_low = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b1; m_p <= '0; m_cnt <= 0;
    end else if (mul_start) begin
      m_done <= 1'b0; m_cnt <= W + 1;
    end else if (!m_done) begin
      if (m_cnt == 0) begin
        m_done <= 1'b1;
        m_p    <= PWID'(mul_a) * PWID'(mul_b);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign mul_done    = dead ? 1'b1 : (hold_low ? 1'b0 : m_done);
  assign mul_product = m_p;

  typedef struct {
    int              idx;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [PWID-1:0] prod;
    logic            err;
    int              t_acc;
  } exp_t;

  exp_t            q[$];
  int              glog[$];
  int              tests = 0, fails = 0;
  int              cyc = 0;
  int              m_ptr = 0;
  bit              cur_stable;
  logic [NREQ-1:0] pend = '0;
  logic [NREQ-1:0] clear_mask = '0;
  logic [W-1:0]    pa[NREQ], pb[NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor / scoreboard: predicts grants from the pending set, checks responses.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_g;
    int              gi, lat;
    exp_t            e;
    if (!rst_n) begin
      q.delete();
      m_ptr      = 0;
      clear_mask = '0;
    end else begin
      exp_g = '0;
      gi    = -1;
      if (q.size() == 0 && mul_done && pend != '0) begin
        for (int k = 0; k < NREQ; k++)
          if (gi < 0 && pend[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
        exp_g[gi] = 1'b1;
      end
      if (q.size() != 0) begin
        e = q[0];
        if (cyc - e.t_acc >= 1 && (mul_a !== e.a || mul_b !== e.b)) cur_stable = 0;
        if (rsp_valid !== '0) begin
          void'(q.pop_front());
          lat = cyc - e.t_acc;
          check("rsp_onehot", 32'(rsp_valid), 32'(1) << e.idx);
          check("rsp_product", 32'(rsp_product), 32'(e.prod));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("busy_resp", 32'(busy), 32'd1);
          check("mul_ab_stable", 32'(cur_stable), 32'd1);
          if (e.err) check("timeout_latency", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 3), 32'd1);
          else       check("latency", 32'(lat), 32'(LAT_NOM));
        end else if (cyc - e.t_acc > TIMEOUT + 12) begin
          check("rsp_missing", 32'(rsp_valid), 32'(1) << e.idx);
          void'(q.pop_front());
        end
      end else if (rsp_valid !== '0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end
      if (req_ready !== '0 || exp_g != '0) begin
        check("req_ready", 32'(req_ready), 32'(exp_g));
        if (exp_g != '0) begin
          check("busy_accept", 32'(busy), 32'd0);
          e.idx   = gi;
          e.a     = pa[gi];
          e.b     = pb[gi];
          e.err   = dead;
          e.prod  = dead ? '0 : PWID'(pa[gi]) * PWID'(pb[gi]);
          e.t_acc = cyc;
          q.push_back(e);
          cur_stable = 1;
          glog.push_back(gi);
          m_ptr = (gi + 1) % NREQ;
          clear_mask[gi] = 1'b1;
        end
      end
    end
  end

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = pa[i];
      req_b[i*W +: W] = pb[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pend       = pend & ~clear_mask;
    clear_mask = '0;
    drive();
  endtask

  task automatic post(input int i, input int a, input int b);
    pend[i] = 1'b1;
    pa[i]   = W'(a);
    pb[i]   = W'(b);
    drive();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q.size() != 0 || pend != '0) && n < budget) begin
      step();
      n++;
    end
    check("wait_idle_bound", 32'(q.size() == 0 && pend == '0), 32'd1);
    step();
    step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_product"}, 32'(rsp_product), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mul_start"}, 32'(mul_start), 32'd0);
    check({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    check({tag, "_mul_b"}, 32'(mul_b), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pb[i] = '0; end
    drive();
    repeat (2) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Single request on requester 1.
    post(1, 5, 3);
    wait_idle(40);

    // Pointer now 2: requester 3 must win over requester 0.
    glog.delete();
    post(0, 7, 2);
    post(3, 3, 4);
    wait_idle(60);
    check("ptr_order_n", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("ptr_order_first", 32'(glog[0]), 32'd3);
      check("ptr_order_second", 32'(glog[1]), 32'd0);
    end

    // Operand extremes.
    post(2, 15, 15);
    wait_idle(40);
    post(0, 0, 9);
    wait_idle(40);

    // Multiplier reporting busy: no grant until it returns to idle.
    glog.delete();
    hold_low = 1;
    post(1, 6, 7);
    repeat (10) step();
    check("no_grant_while_mul_busy", 32'(glog.size()), 32'd0);
    hold_low = 0;
    wait_idle(40);

    // Reset in the middle of a transaction.
    post(2, 11, 13);
    for (int n = 0; n < 20 && q.size() == 0; n++) step();
    check("mid_reset_accepted", 32'(q.size()), 32'd1);
    repeat (3) step();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_zero_outputs("mid_reset");
    step();
    step();
    rst_n = 1'b1;
    repeat (15) step();

    // All requesters at once from pointer 0: strict rotation.
    glog.delete();
    for (int i = 0; i < NREQ; i++) post(i, i + 1, 2);
    wait_idle(100);
    check("rotation_n", 32'(glog.size()), 32'(NREQ));
    for (int k = 0; k < NREQ && k < glog.size(); k++)
      check("rotation_order", 32'(glog[k]), 32'(k));

    // Dead multiplier: watchdog abort.
    dead = 1;
    post(2, 9, 9);
    wait_idle(TIMEOUT + 30);
    dead = 0;
    repeat (12) step();

    // Randomised traffic with occasional withdrawals.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0)
          post(i, $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        int w;
        w = $urandom_range(0, NREQ - 1);
        pend[w] = 1'b0;
        drive();
      end
      repeat ($urandom_range(1, 10)) step();
    end
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
